// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring plus opcode decode into the control word.
// Optional VARIABLE_MACHINE_CYCLE_EN ends each instruction right after its last useful T-state.
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm,
    output logic                CE,
    output logic                Li,
    output logic                Ei,
    output logic                La,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lb,
    output logic                Lo,
    output logic                HLT,
    output logic [T_STATES-1:0] t_state,
    output logic                instr_done
);

    typedef enum logic [T_STATES-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    tstate_e     state_q, state_d;
    logic        hlt_q, hlt_d;
    logic        is_nop;
    logic        last_state;
    logic        active;
    logic [11:0] ctrl;

    assign is_nop = !(opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB ||
                      opcode == OP_OUT || opcode == OP_HLT);

    always_comb begin
        last_state = 1'b0;
`ifdef VARIABLE_MACHINE_CYCLE_EN
        case (state_q)
            T3:      last_state = is_nop;
            T4:      last_state = (opcode == OP_OUT);
            T5:      last_state = (opcode == OP_LDA);
            T6:      last_state = 1'b1;
            default: last_state = 1'b0;
        endcase
`else
        last_state = (state_q == T6);
`endif
    end

    // Illegal ring values fall through to T1 even while frozen, so recovery takes one edge.
    always_comb begin
        state_d = state_q;
        hlt_d   = hlt_q;
        case (state_q)
            T1, T2, T3, T4, T5, T6: begin
                if (run && !hlt_q) begin
                    if (state_q == T4 && opcode == OP_HLT) begin
                        hlt_d = 1'b1;
                    end else if (last_state) begin
                        state_d = T1;
                    end else begin
                        case (state_q)
                            T1:      state_d = T2;
                            T2:      state_d = T3;
                            T3:      state_d = T4;
                            T4:      state_d = T5;
                            T5:      state_d = T6;
                            default: state_d = T1;
                        endcase
                    end
                end
            end
            default: state_d = T1;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    assign active = CLR && run && !hlt_q;

    // Control word bit order: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    always_comb begin
        ctrl = '0;
        if (active) begin
            case (state_q)
                T1: ctrl = 12'b0110_0000_0000;
                T2: ctrl = 12'b1000_0000_0000;
                T3: ctrl = 12'b0001_1000_0000;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: ctrl = 12'b0010_0100_0000;
                        OP_OUT:                 ctrl = 12'b0000_0001_0001;
                        default:                ctrl = '0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         ctrl = 12'b0001_0010_0000;
                        OP_ADD, OP_SUB: ctrl = 12'b0001_0000_0010;
                        default:        ctrl = '0;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  ctrl = 12'b0000_0010_0100;
                        OP_SUB:  ctrl = 12'b0000_0010_1100;
                        default: ctrl = '0;
                    endcase
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = ctrl;
    assign HLT        = hlt_q;
    assign t_state    = state_q;
    assign instr_done = active && last_state;

endmodule
